// File: rtl/cbc_dec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  cbc_pkg : shared types for the CBC decryption sequencer
//  rev 1.0 : initial release
// ============================================================================
package cbc_pkg;

   localparam int DEF_BLK_W = 128;

   typedef logic [0:DEF_BLK_W-1] blk_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cbc_dec_ctrl_if.sv
`default_nettype none
// ============================================================================
//  cbc_dec_ctrl_if : host streams, IV load and core handshake bundle
//  rev 1.0 : initial release
// ============================================================================
interface cbc_dec_ctrl_if
   import cbc_pkg::*;
#(
   parameter int BLK_W = DEF_BLK_W,
   parameter int CNT_W = 16
);
   logic               iv_load;
   logic [0:BLK_W-1]   iv;
   logic               in_valid;
   logic               in_ready;
   logic [0:BLK_W-1]   ct;
   logic [0:BLK_W-1]   key;
   logic               core_start;
   logic [0:BLK_W-1]   core_ct;
   logic [0:BLK_W-1]   core_key;
   logic               core_done;
   logic [0:BLK_W-1]   core_pt;
   logic               out_valid;
   logic               out_ready;
   logic [0:BLK_W-1]   pt;
   logic [CNT_W-1:0]   blk_cnt;
   logic               err;

   modport slave (
      input  iv_load, iv, in_valid, ct, key, core_done, core_pt, out_ready,
      output in_ready, core_start, core_ct, core_key, out_valid, pt, blk_cnt, err
   );

   modport master (
      output iv_load, iv, in_valid, ct, key, core_done, core_pt, out_ready,
      input  in_ready, core_start, core_ct, core_key, out_valid, pt, blk_cnt, err
   );
endinterface
`default_nettype wire

// File: rtl/cbc_dec_ctrl_exor.sv
`default_nettype none
// ============================================================================
//  Exor : bitwise XOR of two equal-width vectors (CBC chaining step)
//  rev 1.0 : initial release
// ============================================================================
module Exor #(
   parameter int W = 128
) (
   input  wire logic [0:W-1] a,
   input  wire logic [0:W-1] b,
   output logic      [0:W-1] y
);
   assign y = a ^ b;
endmodule
`default_nettype wire

// File: rtl/cbc_dec_ctrl.sv
`default_nettype none
// ============================================================================
//  cbc_dec_ctrl : CBC-mode decryption sequencer around a start/done core
//  rev 1.0 : initial release
// ============================================================================
module cbc_dec_ctrl
   import cbc_pkg::*;
#(
   parameter int BLK_W     = DEF_BLK_W,
   parameter int CNT_W     = 16,
   parameter int TO_CYCLES = 64
) (
   input wire logic      clk,
   input wire logic      rst,
   cbc_dec_ctrl_if.slave bus
);
   localparam int               WD_W    = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
   // Firing one count early makes the err pulse land TO_CYCLES after core_start.
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TO_CYCLES - 2);

   state_t            state;
   logic [0:BLK_W-1]  ct_reg;
   logic [0:BLK_W-1]  key_reg;
   logic [0:BLK_W-1]  chain_reg;
   logic [0:BLK_W-1]  pt_reg;
   logic [0:BLK_W-1]  pt_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [WD_W-1:0]   wd;
   logic              start_reg;
   logic              valid_reg;
   logic              err_reg;

   Exor #(.W(BLK_W)) u_exor (
      .a (bus.core_pt),
      .b (chain_reg),
      .y (pt_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ct_reg    <= '0;
         key_reg   <= '0;
         chain_reg <= '0;
         pt_reg    <= '0;
         cnt_reg   <= '0;
         wd        <= '0;
         start_reg <= 1'b0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         err_reg   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iv_load) begin
                  chain_reg <= bus.iv;
                  cnt_reg   <= '0;
               end else if (bus.in_valid) begin
                  ct_reg    <= bus.ct;
                  key_reg   <= bus.key;
                  start_reg <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               wd    <= '0;
               state <= RUN;
            end
            RUN: begin
               if (bus.core_done) begin
                  pt_reg    <= pt_next;
                  chain_reg <= ct_reg;
                  valid_reg <= 1'b1;
                  state     <= HOLD;
               end else if (wd == WD_LAST) begin
                  // Block is dropped; chaining state stays as before it.
                  err_reg <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  valid_reg <= 1'b0;
                  cnt_reg   <= cnt_reg + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE) && !bus.iv_load;
   assign bus.core_start = start_reg;
   assign bus.core_ct    = ct_reg;
   assign bus.core_key   = key_reg;
   assign bus.out_valid  = valid_reg;
   assign bus.pt         = pt_reg;
   assign bus.blk_cnt    = cnt_reg;
   assign bus.err        = err_reg;

endmodule
`default_nettype wire

// File: tb/tb_cbc_dec_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_cbc_dec_ctrl : scoreboard bench with a 3-cycle ct^key core model
//  rev 1.0 : initial release
// ============================================================================
module tb_cbc_dec_ctrl;
   import cbc_pkg::*;

   localparam int BW  = 128;
   localparam int CW  = 16;
   localparam int TO  = 64;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cbc_dec_ctrl_if #(.BLK_W(BW), .CNT_W(CW)) bus ();

   cbc_dec_ctrl #(.BLK_W(BW), .CNT_W(CW), .TO_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    total = 0;
   int    bad   = 0;
   int    err_seen = 0;
   blk_t  sb[$];
   blk_t  chain_m;
   blk_t  exp_pop;
   logic  core_en;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Core model: result = ct ^ key, core_done LAT cycles after core_start.
   logic busy = 1'b0;
   int   dly  = 0;
   blk_t res;
   always @(posedge clk) begin
      bus.core_done <= 1'b0;
      if (busy) begin
         if (dly <= 1) begin
            bus.core_done <= 1'b1;
            bus.core_pt   <= res;
            busy          <= 1'b0;
         end else begin
            dly <= dly - 1;
         end
      end else if (bus.core_start === 1'b1 && core_en) begin
         busy <= 1'b1;
         dly  <= LAT - 1;
         res  <= bus.core_ct ^ bus.core_key;
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 128'(sb.size() > 0), 128'd1);
            if (sb.size() > 0) begin
               exp_pop = sb.pop_front();
               check("pt_sb", bus.pt, exp_pop);
            end
         end
         if (bus.err === 1'b1) err_seen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_iv(input blk_t v);
      bus.iv      = v;
      bus.iv_load = 1'b1;
      #1;
      check("iv_load_blocks_ready", bus.in_ready, 0);
      tick();
      bus.iv_load = 1'b0;
      chain_m     = v;
   endtask

   task automatic send(input blk_t c, input blk_t k, input bit exp_out);
      int n = 0;
      bus.ct       = c;
      bus.key      = k;
      bus.in_valid = 1'b1;
      #1;
      while (!bus.in_ready && n < 50) begin
         tick();
         #1;
         n++;
      end
      check("accept_wait", 128'(n < 50), 128'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (exp_out) begin
         sb.push_back(c ^ k ^ chain_m);
         chain_m = c;
      end
   endtask

   task automatic wait_out();
      int n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      check("out_wait", 128'(n < 100), 128'd1);
      while (bus.out_valid && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int   n;
      blk_t bp_exp;
      blk_t v;
      rst           = 1'b1;
      core_en       = 1'b1;
      chain_m       = '0;
      bus.iv_load   = 1'b0;
      bus.iv        = '0;
      bus.in_valid  = 1'b0;
      bus.ct        = '0;
      bus.key       = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_pt",        bus.pt,        0);
      check("rst_blk_cnt",   bus.blk_cnt,   0);
      check("rst_err",       bus.err,       0);
      check("rst_core_start",bus.core_start,0);

      // single block with latency measurement
      load_iv(128'h000102030405060708090A0B0C0D0E0F);
      send({BW{1'b1}}, '0, 1);
      check("core_start_pulse", bus.core_start, 1);
      check("core_ct", bus.core_ct, {BW{1'b1}});
      n = 1;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      check("latency", n, 5);
      check("pt_single", bus.pt, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
      wait_out();
      check("cnt_single", bus.blk_cnt, 1);
      check("ready_after_hs", bus.in_ready, 1);

      // chaining
      load_iv('0);
      check("cnt_iv_clear", bus.blk_cnt, 0);
      send({16{8'hA5}}, '0, 1);
      wait_out();
      send({16{8'h5A}}, '0, 1);
      wait_out();
      check("pt_chain2", bus.pt, {BW{1'b1}});
      check("cnt_chain", bus.blk_cnt, 2);

      // backpressure
      bus.out_ready = 1'b0;
      bp_exp = 128'h0123456789ABCDEF0011223344556677 ^ 128'hDEADBEEF00000000CAFEF00D12345678 ^ {16{8'h5A}};
      send(128'h0123456789ABCDEF0011223344556677, 128'hDEADBEEF00000000CAFEF00D12345678, 1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      bus.in_valid = 1'b1;
      bus.ct       = 128'h1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", bus.out_valid, 1);
         check("bp_pt",    bus.pt,        bp_exp);
         check("bp_ready", bus.in_ready,  0);
         check("bp_cnt",   bus.blk_cnt,   2);
         check("bp_start", bus.core_start,0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_cnt",   bus.blk_cnt,   3);
      check("bp_release_ready", bus.in_ready,  1);

      // watchdog timeout
      core_en = 1'b0;
      send(128'hFEEDFACE, 128'h0, 0);
      check("to_core_start", bus.core_start, 1);
      n = 0;
      while (!bus.err && n < 200) begin
         tick();
         n++;
      end
      check("to_latency", n, TO);
      tick();
      check("to_err_pulse", bus.err, 0);
      check("to_idle", bus.in_ready, 1);
      check("to_cnt", bus.blk_cnt, 3);
      core_en = 1'b1;
      send(128'h00112233445566778899AABBCCDDEEFF, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 1);
      wait_out();
      check("to_next_cnt", bus.blk_cnt, 4);

      // iv_load together with in_valid
      v = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00;
      bus.iv_load  = 1'b1;
      bus.iv       = v;
      bus.in_valid = 1'b1;
      bus.ct       = 128'h77;
      bus.key      = 128'h11;
      #1;
      check("ivv_ready_low", bus.in_ready, 0);
      tick();
      bus.iv_load = 1'b0;
      #1;
      check("ivv_ready_high", bus.in_ready, 1);
      chain_m = v;
      send(128'h77, 128'h11, 1);
      wait_out();
      check("ivv_cnt", bus.blk_cnt, 1);

      // iv_load during RUN is ignored
      send(128'h5555AAAA, 128'h3, 1);
      tick();
      bus.iv_load = 1'b1;
      bus.iv      = 128'h123;
      tick();
      bus.iv_load = 1'b0;
      wait_out();
      check("ivrun_cnt", bus.blk_cnt, 2);

      // reset during RUN
      send(128'hABCDEF, 128'h1, 0);
      tick();
      rst = 1'b1;
      #1;
      check("rr_out_valid", bus.out_valid, 0);
      check("rr_pt",        bus.pt,        0);
      check("rr_core_ct",   bus.core_ct,   0);
      check("rr_core_key",  bus.core_key,  0);
      check("rr_cnt",       bus.blk_cnt,   0);
      check("rr_ready",     bus.in_ready,  1);
      tick();
      rst = 1'b0;
      chain_m = '0;
      n = 0;
      repeat (8) begin
         tick();
         if (bus.out_valid) n++;
      end
      check("rr_no_output", n, 0);
      send(128'h9999, 128'h6666, 1);
      wait_out();
      check("rr_after_cnt", bus.blk_cnt, 1);

      check("sb_drained", sb.size(), 0);
      check("err_pulses", err_seen, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
